// File: rtl/clock_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clock_div_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_EVEN   = 2'd2,
        MODE_ODD    = 2'd3
    } div_mode_e;

    // Ratios 0 and 1 pass the source clock straight through.
    localparam int unsigned BYPASS_MAX = 32'd1;

    function automatic logic is_bypass(input int unsigned ratio);
        return (ratio <= BYPASS_MAX);
    endfunction

    function automatic div_mode_e mode_for_ratio(input int unsigned ratio);
        div_mode_e mode;
        if (ratio <= BYPASS_MAX) begin
            mode = MODE_BYPASS;
        end else if (ratio[0]) begin
            mode = MODE_ODD;
        end else begin
            mode = MODE_EVEN;
        end
        return mode;
    endfunction

endpackage

// File: rtl/clock_div_if.sv
// Ratio request and divided clock between the clocking controller and the divider.
interface clock_div_if #(
    parameter int SIZE = 3
);
    logic [SIZE-1:0] N;
    logic            out;

    modport master (output N, input  out);
    modport slave  (input  N, output out);
endinterface

// File: rtl/clock_div_counter.sv
// Modulo-n_eff counter; the ratio is re-captured only at a wrap or while bypassing.
module clock_div_counter
    import clock_div_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic            in,
    input  logic            reset,
    input  logic [SIZE-1:0] ratio,
    output logic [SIZE-1:0] cnt,
    output logic [SIZE-1:0] n_eff
);

    logic [SIZE-1:0] cnt_r;
    logic [SIZE-1:0] n_eff_r;
    logic            bypass_s;
    logic            wrap_s;

    // Decode bypass and last-count-of-period from the held ratio.
    always_comb begin
        bypass_s = is_bypass(32'(n_eff_r));
        wrap_s   = (cnt_r == (n_eff_r - SIZE'(1)));
    end

    // Counter and ratio capture; a new ratio never lands mid-period.
    always_ff @(posedge in) begin
        if (reset) begin
            cnt_r   <= '0;
            n_eff_r <= '0;
        end else if (bypass_s) begin
            cnt_r   <= '0;
            n_eff_r <= ratio;
        end else if (wrap_s) begin
            cnt_r   <= '0;
            n_eff_r <= ratio;
        end else begin
            cnt_r   <= cnt_r + SIZE'(1);
            n_eff_r <= n_eff_r;
        end
    end

    assign cnt   = cnt_r;
    assign n_eff = n_eff_r;

endmodule

// File: rtl/clock_div.sv
// Programmable integer clock divider with 50% duty for odd and even ratios.
module clock_div
    import clock_div_pkg::*;
#(
    parameter int SIZE = 3
) (
    input  logic      in,
    input  logic      reset,
    clock_div_if.slave bus
);

    logic [SIZE-1:0] cnt_s;
    logic [SIZE-1:0] n_eff_s;
    logic [SIZE:0]   half_s;
    logic            bypass_s;
    logic            high_phase_s;
    logic            pos_r;
    logic            neg_r;
    logic            rst_r;
    div_mode_e       mode_r;
    logic            out_s;

    clock_div_counter #(.SIZE(SIZE)) u_counter (
        .in    (in),
        .reset (reset),
        .ratio (bus.N),
        .cnt   (cnt_s),
        .n_eff (n_eff_s)
    );

    // High phase lasts ceil(n_eff/2) counts; odd ratios are trimmed by neg_r.
    always_comb begin
        bypass_s     = is_bypass(32'(n_eff_s));
        half_s       = ({1'b0, n_eff_s} + (SIZE+1)'(1)) >> 1;
        high_phase_s = ({1'b0, cnt_s} < half_s);
    end

    // Duty flop and output blanking flag on the source rising edge.
    always_ff @(posedge in) begin
        if (reset) begin
            pos_r <= 1'b0;
            rst_r <= 1'b1;
        end else begin
            rst_r <= 1'b0;
            if (bypass_s) begin
                pos_r <= 1'b0;
            end else begin
                pos_r <= high_phase_s;
            end
        end
    end

    // Falling-edge stage: half-cycle duty correction and the output mux select,
    // so the select only moves while the source clock is low.
    always_ff @(negedge in) begin
        if (rst_r) begin
            neg_r  <= 1'b0;
            mode_r <= MODE_OFF;
        end else begin
            neg_r  <= pos_r;
            mode_r <= mode_for_ratio(32'(n_eff_s));
        end
    end

    // Output mux; held low during reset and until the first post-reset select.
    always_comb begin
        out_s = 1'b0;
        if (rst_r || (mode_r == MODE_OFF)) begin
            out_s = 1'b0;
        end else begin
            case (mode_r)
                MODE_BYPASS: out_s = in;
                MODE_EVEN:   out_s = pos_r;
                MODE_ODD:    out_s = pos_r & neg_r;
                default:     out_s = 1'b0;
            endcase
        end
    end

    assign bus.out = out_s;

endmodule

// File: tb/tb_clock_div.sv
// Scoreboard bench for clock_div: expected (period, high) pairs are queued by
// the stimulus and popped by an edge monitor on every rising output edge.
module tb_clock_div;
    timeunit 1ns;
    timeprecision 1ps;

    typedef struct {
        string  tag;
        longint period;
        longint high;
    } exp_t;

    logic   in;
    logic   reset;
    exp_t   sb_q[$];
    int     n_vec  = 0;
    int     n_miss = 0;

    longint last_rise = 0;
    longint last_fall = 0;
    bit     rise_ok   = 1'b0;
    bit     fall_ok   = 1'b0;
    bit     armed     = 1'b0;
    longint min_hi    = 64'd1000000;
    longint min_lo    = 64'd1000000;
    bit     got_edge  = 1'b0;

    clock_div_if #(.SIZE(3)) bus ();

    clock_div #(.SIZE(3)) dut (
        .in    (in),
        .reset (reset),
        .bus   (bus)
    );

    initial in = 1'b0;
    always #5 in = ~in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_min(input string name, input longint act, input longint req);
        n_vec++;
        if (act < req) begin
            n_miss++;
            $display("FAIL %s: shortest pulse %0d ns, required at least %0d ns", name, act, req);
        end
    endtask

    // Monitor: rising edge closes one output period and pops the scoreboard.
    always @(posedge bus.out) begin
        exp_t e;
        longint t;
        t = $time;
        if (fall_ok && (t - last_fall) < min_lo) min_lo = t - last_fall;
        if (armed && rise_ok && fall_ok && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.tag, "_period"}, t - last_rise, e.period);
            check({e.tag, "_high"}, last_fall - last_rise, e.high);
        end
        armed     = (sb_q.size() > 0);
        last_rise = t;
        rise_ok   = 1'b1;
    end

    always @(negedge bus.out) begin
        longint t;
        t = $time;
        if (rise_ok && (t - last_rise) < min_hi) min_hi = t - last_rise;
        last_fall = t;
        fall_ok   = 1'b1;
    end

    task automatic tracker_reset();
        rise_ok = 1'b0;
        fall_ok = 1'b0;
        min_hi  = 64'd1000000;
        min_lo  = 64'd1000000;
    endtask

    task automatic push(input string tag, input int count, input longint per, input longint hi);
        exp_t e;
        e.tag = tag;
        e.period = per;
        e.high = hi;
        for (int i = 0; i < count; i++) sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge in);
        end
        check({tag, "_drain_left"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic set_phase(input string tag, input logic [2:0] n, input int count,
                             input longint per, input longint hi);
        @(negedge in);
        bus.N = n;
        repeat (24) @(posedge in);
        push(tag, count, per, hi);
        drain(tag);
    endtask

    task automatic wait_out(input logic level, output longint t);
        got_edge = 1'b0;
        fork
            begin
                if (level) @(posedge bus.out);
                else       @(negedge bus.out);
                got_edge = 1'b1;
            end
            begin
                repeat (100) @(posedge in);
            end
        join_any
        disable fork;
        t = $time;
        check("out_edge_seen", got_edge, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint r0;
        longint f0;
        reset = 1'b1;
        bus.N = 3'd0;

        // Reset with bypass ratio: out held low even while in is high.
        @(posedge in);
        for (int i = 0; i < 5; i++) begin
            @(posedge in);
            #2;
            check("reset_out_low", bus.out, 0);
        end
        @(negedge in);
        reset = 1'b0;
        tracker_reset();
        push("bypass0", 3, 10, 5);
        drain("bypass0");
        @(posedge in); #2;
        check("bypass_no_x_hi", $isunknown(bus.out), 0);
        check("bypass_follow_hi", bus.out, 1);
        @(negedge in); #2;
        check("bypass_no_x_lo", $isunknown(bus.out), 0);

        // Even ratios, then back to bypass; no pulse shorter than half an input cycle.
        tracker_reset();
        set_phase("div2", 3'd2, 5, 20, 10);
        set_phase("div4", 3'd4, 5, 40, 20);
        set_phase("bypass1", 3'd0, 3, 10, 5);
        check_min("bypass_div_min_high", min_hi, 5);
        check_min("bypass_div_min_low", min_lo, 5);

        // Odd ratios rely on the falling-edge duty correction.
        set_phase("div3", 3'd3, 5, 30, 15);
        set_phase("div5", 3'd5, 5, 50, 25);
        set_phase("div3b", 3'd3, 3, 30, 15);

        // Mid-period change 3 -> 2: old high phase completes, then 20 ns periods.
        tracker_reset();
        wait_out(1'b1, r0);
        #3;
        bus.N = 3'd2;
        push("div3to2", 4, 20, 10);
        wait_out(1'b0, f0);
        check("div3to2_old_high", f0 - r0, 15);
        drain("div3to2");
        check_min("div3to2_min_high", min_hi, 10);
        check_min("div3to2_min_low", min_lo, 10);

        // Reset in the middle of a divide-by-5 high phase.
        set_phase("div5b", 3'd5, 3, 50, 25);
        wait_out(1'b1, r0);
        #2;
        reset = 1'b1;
        @(posedge in);
        #1;
        check("midreset_out_low", bus.out, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge in);
            #2;
            check("midreset_hold_low", bus.out, 0);
        end
        @(negedge in);
        reset = 1'b0;
        tracker_reset();
        push("div5_after_reset", 3, 50, 25);
        drain("div5_after_reset");
        check_min("after_reset_min_high", min_hi, 25);
        check_min("after_reset_min_low", min_lo, 25);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
